// File: rtl/rom_read_arbiter_if.sv
// Two requester read ports plus the ROM side of the shared image-ROM read path.
// The slave modport belongs to the arbiter; master is the surrounding environment.
interface rom_read_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 24
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              gnt0;
    logic              rvalid0;

    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              gnt1;
    logic              rvalid1;

    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] rdata;
    logic              oor_err;

    modport slave (
        input  req0, addr0, req1, addr1, rom_data,
        output gnt0, rvalid0, gnt1, rvalid1, rom_addr, rdata, oor_err
    );

    modport master (
        output req0, addr0, req1, addr1, rom_data,
        input  gnt0, rvalid0, gnt1, rvalid1, rom_addr, rdata, oor_err
    );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin sharing of the image-ROM read port between scan-out (0) and scroll engine (1).
// Latency: grant is combinational; tagged rvalid/rdata follow one cycle later.
// Backpressure: a requester holds req until gnt; an owner keeps the port for at most MAX_BURST grants while the other waits.
module rom_read_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 24,
    parameter int DEPTH     = 4800,
    parameter int MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             rst,
    rom_read_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t            state_q, state_d;
    logic              last_owner_q, last_owner_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              v0_q, v1_q, oor_q;

    logic              g0, g1;
    logic              gnt0_w, gnt1_w, any_gnt;
    logic [ADDR_W-1:0] grant_addr;
    logic              in_range;
    logic [CNT_W-1:0]  cnt_inc;

    assign cnt_inc = (burst_cnt_q == CNT_MAX) ? burst_cnt_q : burst_cnt_q + CNT_ONE;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        g0           = 1'b0;
        g1           = 1'b0;
        case (state_q)
            IDLE: begin
                // Ties go to whoever did not own the port most recently.
                if (bus.req0 && (!bus.req1 || last_owner_q)) begin
                    g0          = 1'b1;
                    state_d     = OWN0;
                    burst_cnt_d = CNT_ONE;
                end else if (bus.req1) begin
                    g1          = 1'b1;
                    state_d     = OWN1;
                    burst_cnt_d = CNT_ONE;
                end
            end
            OWN0: begin
                if (bus.req0 && !(bus.req1 && burst_cnt_q == CNT_MAX)) begin
                    g0          = 1'b1;
                    burst_cnt_d = cnt_inc;
                end else begin
                    last_owner_d = 1'b0;
                    if (bus.req1) begin
                        g1          = 1'b1;
                        state_d     = OWN1;
                        burst_cnt_d = CNT_ONE;
                    end else begin
                        state_d     = IDLE;
                        burst_cnt_d = '0;
                    end
                end
            end
            OWN1: begin
                if (bus.req1 && !(bus.req0 && burst_cnt_q == CNT_MAX)) begin
                    g1          = 1'b1;
                    burst_cnt_d = cnt_inc;
                end else begin
                    last_owner_d = 1'b1;
                    if (bus.req0) begin
                        g0          = 1'b1;
                        state_d     = OWN0;
                        burst_cnt_d = CNT_ONE;
                    end else begin
                        state_d     = IDLE;
                        burst_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // Outputs are held quiet for the whole reset cycle, including any result already in flight.
    assign gnt0_w     = g0 & ~rst;
    assign gnt1_w     = g1 & ~rst;
    assign any_gnt    = gnt0_w | gnt1_w;
    assign grant_addr = gnt0_w ? bus.addr0 : bus.addr1;
    assign in_range   = ({1'b0, grant_addr} < DEPTH_C);

    assign bus.gnt0     = gnt0_w;
    assign bus.gnt1     = gnt1_w;
    assign bus.rom_addr = (any_gnt && in_range) ? grant_addr : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= '0;
            v0_q         <= 1'b0;
            v1_q         <= 1'b0;
            oor_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            v0_q         <= g0;
            v1_q         <= g1;
            oor_q        <= (g0 | g1) & ~in_range;
        end
    end

    assign bus.rvalid0 = v0_q & ~rst;
    assign bus.rvalid1 = v1_q & ~rst;
    assign bus.oor_err = oor_q & ~rst;
    assign bus.rdata   = ((v0_q | v1_q) && !oor_q && !rst) ? bus.rom_data : '0;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter with a grant-history reference model and hand-computed checks.
module tb_rom_read_arbiter;
    localparam int ADDR_W    = 13;
    localparam int DATA_W    = 24;
    localparam int DEPTH     = 4800;
    localparam int MAX_BURST = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    rom_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rom_read_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] rom_fn(input logic [12:0] a);
        return {a, 11'h2AB};
    endfunction

    // One-cycle synchronous ROM.
    always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arbitration decided from the history of past grants.
    int          m_prev = -1;
    int          m_run  = 0;
    int          m_last = 1;
    logic        pv0 = 1'b0, pv1 = 1'b0;
    logic [12:0] p_addr = '0;

    always @(negedge clk) begin : model_cmp
        int          g;
        logic [12:0] ga;
        logic        r0, r1, pv;
        r0 = bus.req0;
        r1 = bus.req1;
        if (rst) begin
            chk("m_gnt0", {31'd0, bus.gnt0}, 0);
            chk("m_gnt1", {31'd0, bus.gnt1}, 0);
            chk("m_rvalid0", {31'd0, bus.rvalid0}, 0);
            chk("m_rvalid1", {31'd0, bus.rvalid1}, 0);
            chk("m_rom_addr", {19'd0, bus.rom_addr}, 0);
            chk("m_rdata", {8'd0, bus.rdata}, 0);
            chk("m_oor", {31'd0, bus.oor_err}, 0);
            m_prev = -1; m_run = 0; m_last = 1; pv0 = 1'b0; pv1 = 1'b0;
        end else begin
            if (!r0 && !r1)       g = -1;
            else if (r0 != r1)    g = r0 ? 0 : 1;
            else if (m_prev < 0)  g = (m_last == 1) ? 0 : 1;
            else if (m_run >= MAX_BURST) g = 1 - m_prev;
            else                  g = m_prev;
            ga = (g == 0) ? bus.addr0 : bus.addr1;
            pv = pv0 | pv1;
            chk("m_gnt0", {31'd0, bus.gnt0}, {31'd0, g == 0});
            chk("m_gnt1", {31'd0, bus.gnt1}, {31'd0, g == 1});
            chk("m_rom_addr", {19'd0, bus.rom_addr},
                (g >= 0 && int'(ga) < DEPTH) ? {19'd0, ga} : 32'd0);
            chk("m_rvalid0", {31'd0, bus.rvalid0}, {31'd0, pv0});
            chk("m_rvalid1", {31'd0, bus.rvalid1}, {31'd0, pv1});
            chk("m_rdata", {8'd0, bus.rdata},
                (pv && int'(p_addr) < DEPTH) ? {8'd0, rom_fn(p_addr)} : 32'd0);
            chk("m_oor", {31'd0, bus.oor_err}, {31'd0, pv && int'(p_addr) >= DEPTH});
            if (g >= 0 && g == m_prev) m_run = (m_run < MAX_BURST) ? m_run + 1 : MAX_BURST;
            else if (g >= 0)           m_run = 1;
            else                       m_run = 0;
            if (m_prev >= 0 && g != m_prev) m_last = m_prev;
            m_prev = g;
            pv0 = (g == 0);
            pv1 = (g == 1);
            p_addr = ga;
        end
    end

    task automatic drive(input logic r0, input int a0, input logic r1, input int a1);
        @(posedge clk); #1;
        bus.req0 = r0; bus.addr0 = 13'(a0);
        bus.req1 = r1; bus.addr1 = 13'(a1);
    endtask

    task automatic settle;
        @(negedge clk); #1;
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.req0 = 1'b0; bus.addr0 = '0;
        bus.req1 = 1'b0; bus.addr1 = '0;

        // Requests during reset are never granted.
        drive(1, 5, 1, 6);
        settle;
        chk("rst_gnt0", {31'd0, bus.gnt0}, 0);
        chk("rst_rom_addr", {19'd0, bus.rom_addr}, 0);
        do_reset;

        // Single read.
        drive(1, 5, 0, 0);
        settle;
        chk("single_gnt0", {31'd0, bus.gnt0}, 1);
        chk("single_rom_addr", {19'd0, bus.rom_addr}, 32'h5);
        drive(0, 0, 0, 0);
        settle;
        chk("single_rvalid0", {31'd0, bus.rvalid0}, 1);
        chk("single_rvalid1", {31'd0, bus.rvalid1}, 0);
        chk("single_rdata", {8'd0, bus.rdata}, 32'h002AAB);

        // Both held: 8 grants each, alternating.
        do_reset;
        for (int i = 1; i <= 17; i++) begin
            drive(1, i, 1, 100 + i);
            settle;
            chk("burst_gnt0", {31'd0, bus.gnt0}, {31'd0, (i <= 8) || (i == 17)});
            chk("burst_gnt1", {31'd0, bus.gnt1}, {31'd0, (i >= 9) && (i <= 16)});
        end
        drive(0, 0, 0, 0);

        // Long solo run by requester 1 saturates the burst counter.
        do_reset;
        for (int i = 1; i <= 20; i++) begin
            drive(i == 20, 200, 1, i);
            settle;
            chk("scroll_gnt1", {31'd0, bus.gnt1}, {31'd0, i < 20});
            chk("scroll_gnt0", {31'd0, bus.gnt0}, {31'd0, i == 20});
        end
        drive(0, 0, 0, 0);
        settle;
        chk("scroll_rvalid0", {31'd0, bus.rvalid0}, 1);
        chk("scroll_rvalid1", {31'd0, bus.rvalid1}, 0);
        chk("scroll_rdata", {8'd0, bus.rdata}, 32'h0642AB);

        // Out-of-range addresses and the last valid word.
        drive(1, 4800, 0, 0);
        settle;
        chk("oor_gnt0", {31'd0, bus.gnt0}, 1);
        chk("oor_rom_addr_4800", {19'd0, bus.rom_addr}, 0);
        drive(1, 8191, 0, 0);
        settle;
        chk("oor_rom_addr_8191", {19'd0, bus.rom_addr}, 0);
        chk("oor_rvalid_4800", {31'd0, bus.rvalid0}, 1);
        chk("oor_rdata_4800", {8'd0, bus.rdata}, 0);
        chk("oor_err_4800", {31'd0, bus.oor_err}, 1);
        drive(1, 4799, 0, 0);
        settle;
        chk("oor_rom_addr_4799", {19'd0, bus.rom_addr}, 32'd4799);
        chk("oor_rdata_8191", {8'd0, bus.rdata}, 0);
        chk("oor_err_8191", {31'd0, bus.oor_err}, 1);
        drive(0, 0, 0, 0);
        settle;
        chk("last_rvalid0", {31'd0, bus.rvalid0}, 1);
        chk("last_rdata", {8'd0, bus.rdata}, 32'h95FAAB);
        chk("last_oor", {31'd0, bus.oor_err}, 0);

        // Reset right after a grant discards the in-flight result.
        drive(0, 0, 1, 7);
        settle;
        chk("mid_gnt1", {31'd0, bus.gnt1}, 1);
        drive(1, 1, 1, 2);
        rst = 1'b1;
        settle;
        chk("mid_rvalid1", {31'd0, bus.rvalid1}, 0);
        chk("mid_rdata", {8'd0, bus.rdata}, 0);
        chk("mid_gnt0", {31'd0, bus.gnt0}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        settle;
        chk("post_rst_gnt0", {31'd0, bus.gnt0}, 1);
        chk("post_rst_gnt1", {31'd0, bus.gnt1}, 0);
        drive(0, 0, 0, 0);

        // Alternating single-cycle requests.
        for (int i = 0; i < 12; i++) begin
            drive(i % 2 == 0, 300 + i, i % 2 == 1, 400 + i);
            settle;
            chk("alt_gnt0", {31'd0, bus.gnt0}, {31'd0, i % 2 == 0});
            chk("alt_gnt1", {31'd0, bus.gnt1}, {31'd0, i % 2 == 1});
            if (i > 0) chk("alt_rvalid0", {31'd0, bus.rvalid0}, {31'd0, i % 2 == 1});
        end
        drive(0, 0, 0, 0);
        settle;
        chk("alt_tail_rvalid1", {31'd0, bus.rvalid1}, 1);

        drive(0, 0, 0, 0);
        settle;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
